// File: rtl/md_seq.sv
// md_seq: multi-cycle multiply/divide sequencer owning the HI/LO pair, with abort and one-deep rollback.
// Optional feature macro: MD_SEQ_MADD_EN enables madd/maddu/msub/msubu (op codes 7-10).
module md_seq #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_op,
  input  logic [31:0] i_dh,
  input  logic [31:0] i_dl,
  input  logic        i_stop,
  input  logic        i_restore,
  output logic        o_start,
  output logic        o_busy,
  output logic        o_invalid,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi, r_lo;
  logic [31:0] r_p_hi, r_p_lo;
  logic [31:0] r_s_hi, r_s_lo;
  logic        r_divz;
  logic        r_busy;
  logic        r_invalid;

  logic        w_idle;
  logic        w_is_mul, w_is_mac, w_is_div, w_legal;
  logic        w_reject;
  logic        w_signed;
  logic [63:0] w_prod, w_mul_res;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_is_mul = (i_op == OP_MULT) || (i_op == OP_MULTU);
  assign w_is_div = (i_op == OP_DIV)  || (i_op == OP_DIVU);

`ifdef MD_SEQ_MADD_EN
  assign w_is_mac = (i_op >= OP_MADD) && (i_op <= OP_MSUBU);
  assign w_legal  = (i_op <= OP_MSUBU);
`else
  assign w_is_mac = 1'b0;
  assign w_legal  = (i_op <= OP_MTLO);
`endif

  // Any nonzero op while a multi-cycle op is in flight is rejected, as is any unknown code.
  assign w_reject = (i_op != OP_NONE) && (!w_legal || !w_idle);
  assign o_start  = w_idle && !i_stop && !i_restore && (w_is_mul || w_is_mac || w_is_div);

  // Low 64 bits of a product of sign/zero-extended operands equal the exact 32x32 result.
  assign w_signed = (i_op == OP_MULT) || (i_op == OP_MADD) || (i_op == OP_MSUB);
  assign w_prod   = w_signed ? ({{32{i_dh[31]}}, i_dh} * {{32{i_dl[31]}}, i_dl})
                             : ({32'd0, i_dh} * {32'd0, i_dl});

`ifdef MD_SEQ_MADD_EN
  logic [63:0] w_acc;
  logic        w_sub;
  assign w_acc     = {r_hi, r_lo};
  assign w_sub     = (i_op == OP_MSUB) || (i_op == OP_MSUBU);
  assign w_mul_res = !w_is_mac ? w_prod : (w_sub ? (w_acc - w_prod) : (w_acc + w_prod));
`else
  assign w_mul_res = w_prod;
`endif

  // Signed divide through magnitudes so INT_MIN / -1 wraps to INT_MIN without overflow.
  logic        w_div_s, w_neg_a, w_neg_b, w_divz;
  logic [31:0] w_mag_a, w_mag_b, w_den, w_uq, w_ur, w_q, w_r;

  assign w_div_s = (i_op == OP_DIV);
  assign w_neg_a = w_div_s && i_dh[31];
  assign w_neg_b = w_div_s && i_dl[31];
  assign w_mag_a = w_neg_a ? (~i_dh + 32'd1) : i_dh;
  assign w_mag_b = w_neg_b ? (~i_dl + 32'd1) : i_dl;
  assign w_divz  = (i_dl == 32'd0);
  assign w_den   = w_divz ? 32'd1 : w_mag_b;
  assign w_uq    = w_mag_a / w_den;
  assign w_ur    = w_mag_a % w_den;
  assign w_q     = (w_neg_a ^ w_neg_b) ? (~w_uq + 32'd1) : w_uq;
  assign w_r     = w_neg_a ? (~w_ur + 32'd1) : w_ur;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 5'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_p_hi    <= 32'd0;
      r_p_lo    <= 32'd0;
      r_s_hi    <= 32'd0;
      r_s_lo    <= 32'd0;
      r_divz    <= 1'b0;
      r_busy    <= 1'b0;
      r_invalid <= 1'b0;
    end else begin
      r_invalid <= w_reject;
      if (i_restore) begin
        r_hi    <= r_s_hi;
        r_lo    <= r_s_lo;
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= 5'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!i_stop) begin
              if (w_is_mul || w_is_mac) begin
                {r_p_hi, r_p_lo} <= w_mul_res;
                r_divz  <= 1'b0;
                r_cnt   <= 5'(MUL_CYCLES - 1);
                r_state <= ST_MUL;
                r_busy  <= 1'b1;
              end else if (w_is_div) begin
                r_p_hi  <= w_r;
                r_p_lo  <= w_q;
                r_divz  <= w_divz;
                r_cnt   <= 5'(DIV_CYCLES - 1);
                r_state <= ST_DIV;
                r_busy  <= 1'b1;
              end else if (i_op == OP_MTHI) begin
                r_s_hi <= r_hi;
                r_s_lo <= r_lo;
                r_hi   <= i_dh;
              end else if (i_op == OP_MTLO) begin
                r_s_hi <= r_hi;
                r_s_lo <= r_lo;
                r_lo   <= i_dh;
              end
            end
          end
          default: begin
            if (i_stop) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_cnt   <= 5'd0;
            end else if (r_cnt == 5'd0) begin
              // A divide by zero still occupies the unit but leaves HI/LO and the snapshot alone.
              if (!r_divz) begin
                r_s_hi <= r_hi;
                r_s_lo <= r_lo;
                r_hi   <= r_p_hi;
                r_lo   <= r_p_lo;
              end
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 5'd1;
            end
          end
        endcase
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_invalid = r_invalid;
  assign o_hi      = r_hi;
  assign o_lo      = r_lo;

endmodule

// File: tb/tb_md_seq.sv
// tb_md_seq: table-driven vectors with a result scoreboard, plus hand sequences for abort/rollback/reject.
module tb_md_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  op;
  logic [31:0] dh, dl;
  logic        stop, restore;
  logic        start, busy, invalid;
  logic [31:0] hi, lo;

  md_seq #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .i_clk(clk), .i_rst(rst), .i_op(op), .i_dh(dh), .i_dl(dl),
    .i_stop(stop), .i_restore(restore),
    .o_start(start), .o_busy(busy), .o_invalid(invalid), .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] pre_hi, pre_lo, dh, dl;
    int          cyc;
    logic [31:0] hi, lo;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [31:0] hi, lo;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic [3:0] o, logic [31:0] ph, logic [31:0] pl, logic [31:0] a,
                              logic [31:0] b, int c, logic [31:0] eh, logic [31:0] el);
    vec_t v;
    v.op = o; v.pre_hi = ph; v.pre_lo = pl; v.dh = a; v.dl = b; v.cyc = c; v.hi = eh; v.lo = el;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mt(logic [3:0] code, logic [31:0] v);
    op = code; dh = v; dl = 32'd0;
    tick;
    op = 4'd0;
  endtask

  task automatic set_hilo(logic [31:0] h, logic [31:0] l);
    mt(4'd5, h);
    mt(4'd6, l);
  endtask

  task automatic issue(string name, logic [3:0] code, logic [31:0] a, logic [31:0] b);
    op = code; dh = a; dl = b;
    #1;
    chk({name, ".start"}, {31'd0, start}, 32'd1);
    @(posedge clk);
    #1;
    op = 4'd0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (busy && n < 64) begin
      n++;
      tick;
    end
  endtask

  initial begin
    int   n, m;
    exp_t e;
    rst = 1'b0; op = 4'd0; dh = 32'd0; dl = 32'd0; stop = 1'b0; restore = 1'b0;

    vecs.push_back(mk(4'd1, 32'h0,  32'h0,  32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA));
    vecs.push_back(mk(4'd2, 32'h0,  32'h0,  32'hFFFFFFFE, 32'd3,        5,  32'h00000002, 32'hFFFFFFFA));
    vecs.push_back(mk(4'd1, 32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'h00000000, 32'h00000001));
    vecs.push_back(mk(4'd1, 32'h9,  32'h9,  32'h00010000, 32'h00010000, 5,  32'h00000001, 32'h00000000));
    vecs.push_back(mk(4'd4, 32'h0,  32'h0,  32'd7,        32'd2,        10, 32'h00000001, 32'h00000003));
    vecs.push_back(mk(4'd3, 32'h0,  32'h0,  32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000));
    vecs.push_back(mk(4'd3, 32'h0,  32'h0,  32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD));
    vecs.push_back(mk(4'd3, 32'h0,  32'h0,  32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD));
    vecs.push_back(mk(4'd4, 32'h0,  32'h0,  32'hFFFFFFF9, 32'd2,        10, 32'h00000001, 32'h7FFFFFFC));
    vecs.push_back(mk(4'd3, 32'h11, 32'h22, 32'd5,        32'd0,        10, 32'h00000011, 32'h00000022));
`ifdef MD_SEQ_MADD_EN
    vecs.push_back(mk(4'd7,  32'h0, 32'd10,       32'd2,        32'd3, 5, 32'h00000000, 32'h00000010));
    vecs.push_back(mk(4'd9,  32'h0, 32'd10,       32'd2,        32'd3, 5, 32'h00000000, 32'h00000004));
    vecs.push_back(mk(4'd10, 32'h0, 32'h0,        32'd1,        32'd1, 5, 32'hFFFFFFFF, 32'hFFFFFFFF));
    vecs.push_back(mk(4'd8,  32'h0, 32'hFFFFFFFF, 32'd1,        32'd1, 5, 32'h00000001, 32'h00000000));
    vecs.push_back(mk(4'd7,  32'h0, 32'h0,        32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE));
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.invalid", {31'd0, invalid}, 32'd0);
    chk("rst.hi", hi, 32'd0);
    chk("rst.lo", lo, 32'd0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      set_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
      e.cyc = vecs[i].cyc; e.hi = vecs[i].hi; e.lo = vecs[i].lo;
      sb.push_back(e);
      issue($sformatf("v%0d", i), vecs[i].op, vecs[i].dh, vecs[i].dl);
      wait_done(n);
      e = sb.pop_front();
      chk($sformatf("v%0d.busy_cycles", i), n, e.cyc);
      chk($sformatf("v%0d.hi", i), hi, e.hi);
      chk($sformatf("v%0d.lo", i), lo, e.lo);
    end

    // stop in busy cycle 3, then mtlo right after
    set_hilo(32'hA, 32'hB);
    issue("stop", 4'd1, 32'd3, 32'd4);
    tick; tick;
    chk("stop.busy_c3", {31'd0, busy}, 32'd1);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk("stop.busy_after", {31'd0, busy}, 32'd0);
    chk("stop.hi", hi, 32'hA);
    chk("stop.lo", lo, 32'hB);
    mt(4'd6, 32'h1234);
    chk("stop.mtlo", lo, 32'h1234);
    chk("stop.mtlo_busy", {31'd0, busy}, 32'd0);

    // stop while idle suppresses issue
    op = 4'd1; dh = 32'd2; dl = 32'd2; stop = 1'b1;
    #1;
    chk("idlestop.start", {31'd0, start}, 32'd0);
    tick;
    op = 4'd0; stop = 1'b0;
    chk("idlestop.busy", {31'd0, busy}, 32'd0);
    chk("idlestop.invalid", {31'd0, invalid}, 32'd0);

    // mthi then restore
    set_hilo(32'd5, 32'd7);
    mt(4'd5, 32'hAAAA);
    chk("rest.mthi", hi, 32'hAAAA);
    restore = 1'b1;
    tick;
    restore = 1'b0;
    chk("rest.hi", hi, 32'd5);
    chk("rest.lo", lo, 32'd7);

    // restore coinciding with the mult commit cycle
    set_hilo(32'h21, 32'h43);
    mt(4'd6, 32'h43);
    issue("rcommit", 4'd1, 32'd3, 32'd4);
    repeat (4) tick;
    chk("rcommit.busy_c5", {31'd0, busy}, 32'd1);
    restore = 1'b1;
    tick;
    restore = 1'b0;
    chk("rcommit.busy", {31'd0, busy}, 32'd0);
    chk("rcommit.hi", hi, 32'h21);
    chk("rcommit.lo", lo, 32'h43);
    tick;
    chk("rcommit.lo_hold", lo, 32'h43);

    // mult requested while divu is busy
    set_hilo(32'h0, 32'h0);
    e.cyc = 10; e.hi = 32'd1; e.lo = 32'd3;
    sb.push_back(e);
    issue("rej", 4'd4, 32'd7, 32'd2);
    op = 4'd1; dh = 32'd100; dl = 32'd100;
    #1;
    chk("rej.start", {31'd0, start}, 32'd0);
    tick;
    op = 4'd0;
    chk("rej.invalid_hi", {31'd0, invalid}, 32'd1);
    tick;
    chk("rej.invalid_lo", {31'd0, invalid}, 32'd0);
    wait_done(m);
    e = sb.pop_front();
    chk("rej.busy_cycles", m + 2, e.cyc);
    chk("rej.hi", hi, e.hi);
    chk("rej.lo", lo, e.lo);
    tick;
    chk("rej.no_mult", {31'd0, busy}, 32'd0);
    chk("rej.lo_hold", lo, 32'd3);

    // unknown op code
    op = 4'd15;
    tick;
    op = 4'd0;
    chk("bad.invalid", {31'd0, invalid}, 32'd1);
    chk("bad.busy", {31'd0, busy}, 32'd0);
    chk("bad.lo", lo, 32'd3);

`ifndef MD_SEQ_MADD_EN
    set_hilo(32'd0, 32'd10);
    op = 4'd7; dh = 32'd2; dl = 32'd3;
    #1;
    chk("nomadd.start", {31'd0, start}, 32'd0);
    tick;
    op = 4'd0;
    chk("nomadd.invalid", {31'd0, invalid}, 32'd1);
    chk("nomadd.busy", {31'd0, busy}, 32'd0);
    repeat (6) tick;
    chk("nomadd.lo", lo, 32'd10);
    chk("nomadd.hi", hi, 32'd0);
`endif

    // reset mid-op, then restore must yield the cleared snapshot
    set_hilo(32'h55, 32'h66);
    issue("rstmid", 4'd1, 32'd3, 32'd4);
    tick;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    chk("rstmid.busy", {31'd0, busy}, 32'd0);
    chk("rstmid.hi", hi, 32'd0);
    chk("rstmid.lo", lo, 32'd0);
    repeat (6) tick;
    chk("rstmid.lo_hold", lo, 32'd0);
    restore = 1'b1;
    tick;
    restore = 1'b0;
    chk("rstmid.snap_hi", hi, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/md_seq.md
# md_seq

Multi-cycle sequencer for the E-stage multiply/divide resource and its HI/LO register pair. It accepts one operation per issue from the E-stage control word and runs it for a fixed latency while asserting `busy`, so the hazard unit can stall later HI/LO readers and new MD ops. Results commit atomically on completion. The sequencer supports abort (`stop`) on E/M flush and rollback (`restore`) of the last HI/LO write when an exception squashes it.

## Interface
- `MUL_CYCLES`, 5: busy cycles for mult/multu (and madd-family when enabled); legal range 1–31.
- `DIV_CYCLES`, 10: busy cycles for div/divu; legal range 1–31.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-low reset.
- `op` input 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; all other codes are invalid.
- `dh` input 32: operand rs (mthi/mtlo source).
- `dl` input 32: operand rt.
- `stop` input 1: abort the in-flight op and block any issue this cycle.
- `restore` input 1: roll HI/LO back to the snapshot.
- `start` output 1: combinational; `op` is a multi-cycle op, accepted this cycle.
- `busy` output 1: registered; a multi-cycle op is in flight.
- `invalid` output 1: registered one-cycle pulse for a rejected `op`.
- `hi`, `lo` output 32: architectural HI/LO.

## Operation
- States: IDLE, MUL, DIV.
- 5-bit down-counter `cnt`.
- Pending registers `p_hi` and `p_lo`, computed at issue.
- Snapshot registers `s_hi` and `s_lo`.
- Issue, in IDLE with `stop`=0 and `restore`=0:
  - op 1/2/7–10: latch the pending result, load `cnt` with `MUL_CYCLES`-1, go to MUL.
  - op 3/4: latch the pending result, load `cnt` with `DIV_CYCLES`-1, go to DIV.
  - op 5/6: write `hi`/`lo` directly at that edge; the state stays IDLE.
- Snapshot: every HI/LO write (commit or mthi/mtlo) first copies the current `hi`/`lo` into `s_hi`/`s_lo`.
- MUL/DIV: `cnt` decrements each cycle. When `cnt`==0, `p_hi`/`p_lo` commit to `hi`/`lo`, then go to IDLE.
- Arithmetic:
  - mult: 64-bit signed product.
  - multu: 64-bit unsigned product.
  - madd/maddu: {hi,lo} plus the product, with {hi,lo} sampled at issue; msub/msubu subtract the product instead. All wrap mod 2^64.
  - div/divu: `lo` = quotient truncated toward zero; `hi` = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF signed gives `lo`=0x80000000, `hi`=0.
  - Divisor 0: the op runs its full latency and HI/LO stay unchanged; no snapshot is taken.
- `op`≠0 while busy, or an invalid code in any state: no effect, `invalid`=1 the next cycle.
- `stop` in MUL/DIV: go to IDLE, discard the pending result, HI/LO unchanged.
- `stop` in IDLE: suppresses the issue of `op`.
- `restore`, any state: `hi`/`lo` take `s_hi`/`s_lo` and the state goes to IDLE, aborting any in-flight op. It takes priority over `stop` and issue.
- A commit and `restore` in the same cycle: `restore` wins, and the commit is dropped.

## Timing
- Reset (`rst`=0 at an edge):
  - state IDLE, `cnt`=0.
  - `hi`=`lo`=`s_hi`=`s_lo`=0, `p_hi`=`p_lo`=0.
  - `busy`=0, `invalid`=0.
- Reset mid-operation discards everything; outputs hold their reset values the next cycle.
- Issue of a latency-N op sampled at the edge ending cycle T:
  - `busy`=1 in cycles T+1 … T+N.
  - The new `hi`/`lo` are visible, with `busy`=0, from cycle T+N+1.
  - A new op may issue in T+N+1.
- `start` is valid in cycle T, so the stall logic covers cycle T; `start`=0 whenever `stop`, `restore` or `busy` is set.
- mthi/mtlo sampled at the end of T: visible in T+1; `busy` never asserts.
- `stop`/`restore` sampled at the end of T: `busy`=0 in T+1.
- `invalid` is high for exactly one cycle (T+1) per rejected request.

## Configuration
- `MD_SEQ_MADD_EN` defined: op codes 7–10 are legal and use `MUL_CYCLES`.
- `MD_SEQ_MADD_EN` undefined: codes 7–10 are invalid (`invalid` pulse, no state change), and the accumulate adder is not built.

## Test plan
- Reset, then mult with `dh`=0xFFFFFFFE, `dl`=3 → `busy`=1 for exactly 5 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
- divu with `dh`=7, `dl`=2 → `busy`=1 for 10 cycles; then `hi`=1, `lo`=3. div with 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0. div by 0 → HI/LO unchanged.
- mult in flight, `stop` at busy cycle 3 → `busy`=0 the next cycle, HI/LO unchanged; a new mtlo of 0x1234 the following cycle → `lo`=0x1234.
- mthi of 0xAAAA with `hi`=5, then `restore` → `hi`=5. `restore` coinciding with a mult commit → HI/LO equal the pre-mult values.
- divu issued, then mult requested while busy → `invalid` is a single-cycle pulse, the divu result is correct, and the mult never executes.
- With `MD_SEQ_MADD_EN`: {hi,lo}={0,10}, madd with 2×3 → `lo`=16 after 5 cycles. Without the macro: the same stimulus gives `invalid`=1 and `lo`=10.
